// File: rtl/path_walker_pkg.sv
// path_walker_pkg: constants shared between the Dijkstra core and the
// path walker.
//   - default bus/index widths and graph size
//   - sentinel written into prev[] for nodes that were never relaxed
//   - prev_offset(): word offset of prev[0] inside the graph image (N*N)
package path_walker_pkg;

  localparam int DEFAULT_MADDR_WIDTH = 32;
  localparam int DEFAULT_MDATA_WIDTH = 32;
  localparam int DEFAULT_MAX_NODES   = 32;
  localparam int DEFAULT_INDEX_WIDTH = 8;

  // All ones in the index field marks "no predecessor".
  localparam logic [DEFAULT_INDEX_WIDTH-1:0] NO_PREVIOUS_NODE = {DEFAULT_INDEX_WIDTH{1'b1}};

  // prev[] follows the N*N adjacency matrix, so it starts N*N words in.
  function automatic logic [63:0] prev_offset(input logic [63:0] n);
    return n * n;
  endfunction

endpackage

// File: rtl/path_walker_prev_addr_gen.sv
// path_walker_prev_addr_gen: byte address of prev[node].
//   address = base_address + (N*N + node) * (MADDR_WIDTH/8), modulo 2**MADDR_WIDTH.
// Ports:
//   base_address     in  base of the graph matrix
//   number_of_nodes  in  N
//   node             in  index j of prev[j]
//   address          out byte address of prev[j]
module path_walker_prev_addr_gen
  import path_walker_pkg::*;
#(
  parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
  input  logic [MADDR_WIDTH-1:0] base_address,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic [INDEX_WIDTH-1:0] node,
  output logic [MADDR_WIDTH-1:0] address
);

  localparam int STRIDE = MADDR_WIDTH / 8;

  logic [MADDR_WIDTH-1:0] offset_s;

  // Word offset in the bus width; overflow wraps like the core's writer.
  assign offset_s = MADDR_WIDTH'(prev_offset(64'(number_of_nodes))) + MADDR_WIDTH'(node);
  assign address  = base_address + offset_s * MADDR_WIDTH'(STRIDE);

endmodule

// File: rtl/path_walker.sv
// path_walker: walks the prev[] array left by the Dijkstra core from
// destination back to source and streams the node indices out.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   start                        one-cycle pulse, latches source/destination/N/base in IDLE
//   source, destination          path end points (stream runs destination -> source)
//   number_of_nodes              N
//   base_address                 base of the graph matrix in BlockRam
//   mem_read_enable, mem_addr    read request; released to Z while the bus is not owned
//   mem_read_ready, mem_read_data  read response; low INDEX_WIDTH bits hold prev node
//   path_node/valid/ready/last   output stream, path_last marks the source node
//   path_length                  nodes accepted so far
//   done, error                  completion status levels, cleared by the next start
module path_walker
  import path_walker_pkg::*;
#(
  parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = DEFAULT_MDATA_WIDTH,
  parameter int MAX_NODES   = DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] source,
  input  logic [INDEX_WIDTH-1:0] destination,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic [MADDR_WIDTH-1:0] base_address,
  output logic                   mem_read_enable,
  input  logic                   mem_read_ready,
  output logic [MADDR_WIDTH-1:0] mem_addr,
  input  logic [MDATA_WIDTH-1:0] mem_read_data,
  output logic [INDEX_WIDTH-1:0] path_node,
  output logic                   path_valid,
  input  logic                   path_ready,
  output logic                   path_last,
  output logic [INDEX_WIDTH-1:0] path_length,
  output logic                   done,
  output logic                   error
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EMIT    = 3'd1,
    ST_REQ     = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_FINISH  = 3'd5
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] NO_PREV       = {INDEX_WIDTH{1'b1}};
  localparam logic [INDEX_WIDTH:0]   MAX_NODES_EXT = (INDEX_WIDTH + 1)'(MAX_NODES);

  state_t                 state_r, state_s;
  logic [INDEX_WIDTH-1:0] cur_r, cur_s;
  logic [INDEX_WIDTH-1:0] src_r, src_s;
  logic [INDEX_WIDTH-1:0] n_r, n_s;
  logic [MADDR_WIDTH-1:0] base_r, base_s;
  logic [INDEX_WIDTH-1:0] nxt_r, nxt_s;
  logic [INDEX_WIDTH-1:0] len_r, len_s;
  logic [INDEX_WIDTH-1:0] node_r, node_s;
  logic                   valid_r, valid_s;
  logic                   last_r, last_s;
  logic                   done_r, done_s;
  logic                   error_r, error_s;
  logic                   rd_en_r, rd_en_s;
  logic                   own_r, own_s;
  logic [MADDR_WIDTH-1:0] addr_r, addr_s;
  logic [MADDR_WIDTH-1:0] prev_addr_s;
  logic                   unused_data_s;

  path_walker_prev_addr_gen #(
    .MADDR_WIDTH (MADDR_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_prev_addr_gen (
    .base_address    (base_r),
    .number_of_nodes (n_r),
    .node            (cur_r),
    .address         (prev_addr_s)
  );

  // Only the index field of a prev[] word carries information.
  assign unused_data_s = ^mem_read_data[MDATA_WIDTH-1:INDEX_WIDTH];

  // The read port floats whenever this block does not own the shared bus.
  assign mem_read_enable = own_r ? rd_en_r : 1'bz;
  assign mem_addr        = own_r ? addr_r  : {MADDR_WIDTH{1'bz}};

  assign path_node   = node_r;
  assign path_valid  = valid_r;
  assign path_last   = last_r;
  assign path_length = len_r;
  assign done        = done_r;
  assign error       = error_r;

  // Next-state and next-output logic; every register holds unless a state changes it.
  always_comb begin
    state_s = state_r;
    cur_s   = cur_r;
    src_s   = src_r;
    n_s     = n_r;
    base_s  = base_r;
    nxt_s   = nxt_r;
    len_s   = len_r;
    node_s  = node_r;
    valid_s = valid_r;
    last_s  = last_r;
    done_s  = done_r;
    error_s = error_r;
    rd_en_s = rd_en_r;
    own_s   = own_r;
    addr_s  = addr_r;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          src_s   = source;
          n_s     = number_of_nodes;
          base_s  = base_address;
          cur_s   = destination;
          len_s   = {INDEX_WIDTH{1'b0}};
          done_s  = 1'b0;
          error_s = 1'b0;
          // Oversized graphs are rejected like an out-of-range destination.
          if ((destination >= number_of_nodes) || ({1'b0, number_of_nodes} > MAX_NODES_EXT)) begin
            error_s = 1'b1;
            state_s = ST_FINISH;
          end else begin
            valid_s = 1'b1;
            node_s  = destination;
            last_s  = (destination == source);
            state_s = ST_EMIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_EMIT: begin
        if (path_ready) begin
          len_s   = len_r + INDEX_WIDTH'(1);
          valid_s = 1'b0;
          if (last_r) begin
            last_s  = 1'b0;
            done_s  = 1'b1;
            state_s = ST_FINISH;
          end else begin
            // Request is registered here so enable/address are live during REQ.
            own_s   = 1'b1;
            rd_en_s = 1'b1;
            addr_s  = prev_addr_s;
            state_s = ST_REQ;
          end
        end else begin
          state_s = ST_EMIT;
        end
      end

      ST_REQ: begin
        state_s = ST_WAIT;
      end

      ST_WAIT: begin
        if (mem_read_ready) begin
          nxt_s   = mem_read_data[INDEX_WIDTH-1:0];
          rd_en_s = 1'b0;
          state_s = ST_RELEASE;
        end else begin
          state_s = ST_WAIT;
        end
      end

      ST_RELEASE: begin
        own_s  = 1'b0;
        addr_s = {MADDR_WIDTH{1'b0}};
        // Length reaching N without hitting the source means prev[] loops.
        if ((nxt_r == NO_PREV) || (nxt_r >= n_r) || (len_r == n_r)) begin
          error_s = 1'b1;
          state_s = ST_FINISH;
        end else begin
          cur_s   = nxt_r;
          valid_s = 1'b1;
          node_s  = nxt_r;
          last_s  = (nxt_r == src_r);
          state_s = ST_EMIT;
        end
      end

      ST_FINISH: begin
        own_s   = 1'b0;
        rd_en_s = 1'b0;
        valid_s = 1'b0;
        last_s  = 1'b0;
        state_s = ST_IDLE;
      end

      default: begin
        own_s   = 1'b0;
        rd_en_s = 1'b0;
        valid_s = 1'b0;
        last_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cur_r   <= {INDEX_WIDTH{1'b0}};
      src_r   <= {INDEX_WIDTH{1'b0}};
      n_r     <= {INDEX_WIDTH{1'b0}};
      base_r  <= {MADDR_WIDTH{1'b0}};
      nxt_r   <= {INDEX_WIDTH{1'b0}};
      len_r   <= {INDEX_WIDTH{1'b0}};
      node_r  <= {INDEX_WIDTH{1'b0}};
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
      rd_en_r <= 1'b0;
      own_r   <= 1'b0;
      addr_r  <= {MADDR_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      cur_r   <= cur_s;
      src_r   <= src_s;
      n_r     <= n_s;
      base_r  <= base_s;
      nxt_r   <= nxt_s;
      len_r   <= len_s;
      node_r  <= node_s;
      valid_r <= valid_s;
      last_r  <= last_s;
      done_r  <= done_s;
      error_r <= error_s;
      rd_en_r <= rd_en_s;
      own_r   <= own_s;
      addr_r  <= addr_s;
    end
  end

endmodule

// File: tb/tb_path_walker.sv
// tb_path_walker: directed test of path_walker against a BlockRam model
// preloaded with hand-computed prev[] words (N=8, base 0x1000, so
// prev[j] sits at 0x1100 + 4*j).
module tb_path_walker;
  import path_walker_pkg::*;

  localparam int MAW = 32;
  localparam int MDW = 32;
  localparam int IW  = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic [IW-1:0]  source;
  logic [IW-1:0]  destination;
  logic [IW-1:0]  number_of_nodes;
  logic [MAW-1:0] base_address;
  wire            mem_read_enable;
  logic           mem_read_ready;
  wire  [MAW-1:0] mem_addr;
  logic [MDW-1:0] mem_read_data;
  logic [IW-1:0]  path_node;
  logic           path_valid;
  logic           path_ready;
  logic           path_last;
  logic [IW-1:0]  path_length;
  logic           done;
  logic           error;

  path_walker #(
    .MADDR_WIDTH (MAW),
    .MDATA_WIDTH (MDW),
    .MAX_NODES   (32),
    .INDEX_WIDTH (IW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .source          (source),
    .destination     (destination),
    .number_of_nodes (number_of_nodes),
    .base_address    (base_address),
    .mem_read_enable (mem_read_enable),
    .mem_read_ready  (mem_read_ready),
    .mem_addr        (mem_addr),
    .mem_read_data   (mem_read_data),
    .path_node       (path_node),
    .path_valid      (path_valid),
    .path_ready      (path_ready),
    .path_last       (path_last),
    .path_length     (path_length),
    .done            (done),
    .error           (error)
  );

  always #5 clock = ~clock;

  logic [MDW-1:0] mem [logic [MAW-1:0]];
  int             tests = 0;
  int             fails = 0;
  int             en_cnt = 0;
  int             rd_pulses = 0;
  bit             en_d = 1'b0;
  bit             toggle_mode = 1'b0;
  bit             hold_pending = 1'b0;
  logic [IW-1:0]  hold_node;
  int             stab_err = 0;
  logic [MAW-1:0] addr_q[$];
  int             nodes_q[$];
  int             last_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // BlockRam model (ready two falling edges after enable rises) and stream consumer.
  always @(negedge clock) begin
    if (mem_read_enable === 1'b1) begin
      if (!en_d) begin
        rd_pulses++;
        addr_q.push_back(mem_addr);
      end
      en_cnt++;
      en_d = 1'b1;
      mem_read_data = mem.exists(mem_addr) ? mem[mem_addr] : 32'hFFFF_FFFF;
    end else begin
      en_cnt = 0;
      en_d = 1'b0;
      mem_read_data = 32'h0000_0000;
    end
    mem_read_ready = (en_cnt >= 2);

    path_ready = toggle_mode ? ~path_ready : 1'b1;
    if (path_valid === 1'b1) begin
      if (hold_pending && (path_node !== hold_node)) stab_err++;
      if (path_ready) begin
        nodes_q.push_back(int'(path_node));
        last_q.push_back(int'(path_last));
        hold_pending = 1'b0;
      end else begin
        hold_pending = 1'b1;
        hold_node = path_node;
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic load_graph();
    mem.delete();
    mem[32'h0000_111C] = 32'hABCD_0005;  // prev[7] = 5
    mem[32'h0000_1114] = 32'h1234_5602;  // prev[5] = 2
    mem[32'h0000_1108] = 32'h7700_0000;  // prev[2] = 0
    mem[32'h0000_1118] = {24'h000000, NO_PREVIOUS_NODE};  // prev[6] unreachable
    mem[32'h0000_1110] = 32'h0000_0001;  // prev[4] = 1
    mem[32'h0000_1104] = 32'h0000_0004;  // prev[1] = 4
  endtask

  task automatic run_walk(input logic [IW-1:0] s, input logic [IW-1:0] d, input bit tog);
    bit finished;
    nodes_q.delete();
    last_q.delete();
    addr_q.delete();
    rd_pulses = 0;
    stab_err = 0;
    toggle_mode = tog;
    @(negedge clock);
    source = s;
    destination = d;
    number_of_nodes = 8'd8;
    base_address = 32'h0000_1000;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    finished = 1'b0;
    for (int i = 0; i < 400 && !finished; i++) begin
      @(negedge clock);
      if ((done === 1'b1) || (error === 1'b1)) finished = 1'b1;
    end
    repeat (3) @(negedge clock);
    check_eq("walk_finished", 32'(finished), 32'd1);
    check_eq("valid_idle", 32'(path_valid), 32'd0);
    check_eq("bus_released", 32'(mem_read_enable === 1'b1), 32'd0);
  endtask

  task automatic check_stream(input string tag, input int exp_q[$], input int last_idx);
    check_eq({tag, "_count"}, 32'(nodes_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq({tag, "_node"}, (i < nodes_q.size()) ? 32'(nodes_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
      check_eq({tag, "_last"}, (i < last_q.size()) ? 32'(last_q[i]) : 32'hFFFF_FFFF,
               (i == last_idx) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int  exp_q[$];
    bit  seen;
    reset = 1'b1;
    start = 1'b0;
    source = 8'd0;
    destination = 8'd0;
    number_of_nodes = 8'd0;
    base_address = 32'h0000_0000;
    path_ready = 1'b1;
    mem_read_ready = 1'b0;
    mem_read_data = 32'h0000_0000;
    load_graph();
    repeat (3) @(negedge clock);
    check_eq("rst_valid", 32'(path_valid), 32'd0);
    check_eq("rst_last", 32'(path_last), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_node", 32'(path_node), 32'd0);
    check_eq("rst_length", 32'(path_length), 32'd0);
    check_eq("rst_bus", 32'(mem_read_enable === 1'b1), 32'd0);
    reset = 1'b0;

    // 7 -> 5 -> 2 -> 0 with a always-ready consumer.
    run_walk(8'd0, 8'd7, 1'b0);
    exp_q = '{7, 5, 2, 0};
    check_stream("w1", exp_q, 3);
    check_eq("w1_length", 32'(path_length), 32'd4);
    check_eq("w1_done", 32'(done), 32'd1);
    check_eq("w1_error", 32'(error), 32'd0);
    check_eq("w1_reads", 32'(rd_pulses), 32'd3);
    check_eq("w1_addr0", (addr_q.size() > 0) ? addr_q[0] : 32'hFFFF_FFFF, 32'h0000_111C);
    check_eq("w1_addr1", (addr_q.size() > 1) ? addr_q[1] : 32'hFFFF_FFFF, 32'h0000_1114);
    check_eq("w1_addr2", (addr_q.size() > 2) ? addr_q[2] : 32'hFFFF_FFFF, 32'h0000_1108);

    // Same path with a back-pressuring consumer.
    run_walk(8'd0, 8'd7, 1'b1);
    check_stream("w2", exp_q, 3);
    check_eq("w2_stable", 32'(stab_err), 32'd0);
    check_eq("w2_length", 32'(path_length), 32'd4);
    check_eq("w2_done", 32'(done), 32'd1);

    // Source equals destination: one node, no memory traffic.
    run_walk(8'd3, 8'd3, 1'b0);
    exp_q = '{3};
    check_stream("w3", exp_q, 0);
    check_eq("w3_reads", 32'(rd_pulses), 32'd0);
    check_eq("w3_done", 32'(done), 32'd1);
    check_eq("w3_length", 32'(path_length), 32'd1);

    // Unreachable destination.
    run_walk(8'd0, 8'd6, 1'b0);
    exp_q = '{6};
    check_stream("w4", exp_q, -1);
    check_eq("w4_error", 32'(error), 32'd1);
    check_eq("w4_done", 32'(done), 32'd0);
    check_eq("w4_reads", 32'(rd_pulses), 32'd1);

    // prev[] cycle 4 <-> 1: stops once N nodes have gone out.
    run_walk(8'd0, 8'd4, 1'b0);
    exp_q = '{4, 1, 4, 1, 4, 1, 4, 1};
    check_stream("w5", exp_q, -1);
    check_eq("w5_error", 32'(error), 32'd1);
    check_eq("w5_done", 32'(done), 32'd0);
    check_eq("w5_length", 32'(path_length), 32'd8);

    // Destination equal to N is out of range.
    run_walk(8'd0, 8'd8, 1'b0);
    check_eq("w6_count", 32'(nodes_q.size()), 32'd0);
    check_eq("w6_error", 32'(error), 32'd1);
    check_eq("w6_reads", 32'(rd_pulses), 32'd0);

    // Reset while waiting for read data, then a clean rerun.
    toggle_mode = 1'b0;
    @(negedge clock);
    source = 8'd0;
    destination = 8'd7;
    number_of_nodes = 8'd8;
    base_address = 32'h0000_1000;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      if (mem_read_enable === 1'b1) seen = 1'b1;
    end
    check_eq("rw_req_seen", 32'(seen), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("rw_valid", 32'(path_valid), 32'd0);
    check_eq("rw_last", 32'(path_last), 32'd0);
    check_eq("rw_done", 32'(done), 32'd0);
    check_eq("rw_error", 32'(error), 32'd0);
    check_eq("rw_node", 32'(path_node), 32'd0);
    check_eq("rw_length", 32'(path_length), 32'd0);
    check_eq("rw_bus", 32'(mem_read_enable === 1'b1), 32'd0);
    reset = 1'b0;
    run_walk(8'd0, 8'd7, 1'b0);
    exp_q = '{7, 5, 2, 0};
    check_stream("rw2", exp_q, 3);
    check_eq("rw2_done", 32'(done), 32'd1);
    check_eq("rw2_error", 32'(error), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case the bench itself stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/path_walker.md
Name: path_walker

Overview:
- Reconstructs the shortest path after the Dijkstra core finishes. Reads the prev[] array that the core writes to shared memory at base_address + (N*N + j)*(MADDR_WIDTH/8).
- Walks prev[] from destination back to source and streams node indices out with valid/ready.
- Acts as the memory reader on the same BlockRam bus the core writes through, and takes the bus only after the core's ready is seen.

Parameters:
- MADDR_WIDTH, `DEFAULT_MADDR_WIDTH, memory address width; also sets the byte stride (MADDR_WIDTH/8).
- MDATA_WIDTH, `DEFAULT_MDATA_WIDTH, memory data width.
- MAX_NODES, `DEFAULT_MAX_NODES, maximum graph size.
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH, node index width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches the four config inputs below. Ignored unless in IDLE.
- source  in  INDEX_WIDTH  path origin.
- destination  in  INDEX_WIDTH  path end; the walk starts here.
- number_of_nodes  in  INDEX_WIDTH  N.
- base_address  in  MADDR_WIDTH  base of the graph matrix.
- mem_read_enable  out  1  read request; high-Z when not BUSY.
- mem_read_ready  in  1  read data valid from BlockRam.
- mem_addr  out  MADDR_WIDTH  read address; high-Z when not BUSY.
- mem_read_data  in  MDATA_WIDTH  read data; the low INDEX_WIDTH bits are the prev node.
- path_node  out  INDEX_WIDTH  emitted node index.
- path_valid  out  1  path_node is valid.
- path_ready  in  1  consumer accepts path_node.
- path_last  out  1  qualifies path_node as the source node.
- path_length  out  INDEX_WIDTH  number of nodes emitted so far.
- done  out  1  walk finished; level, held until next start.
- error  out  1  walk aborted; level, held until next start.

Behaviour:
- Reset: state IDLE.
  - path_valid, path_last, done, error = 0.
  - path_node, path_length = 0.
  - mem_read_enable and mem_addr released to Z.
  - Reset mid-walk aborts immediately. No partial output remains asserted the cycle after reset.
- States: IDLE, EMIT, REQ, WAIT, RELEASE, FINISH.
- IDLE, on start:
  - latch config; cur = destination; path_length = 0; clear done and error.
  - If destination >= number_of_nodes: set error, go to FINISH.
  - Otherwise go to EMIT.
- EMIT:
  - path_valid = 1, path_node = cur, path_last = (cur == source).
  - Hold path_node stable until path_valid && path_ready.
  - On the handshake: path_length += 1.
    - If path_last: set done, go to FINISH.
    - Otherwise go to REQ.
- REQ:
  - Drive mem_addr = base + (N*N + cur)*(MADDR_WIDTH/8), computed in MADDR_WIDTH bits with wrap ignored.
  - Assert mem_read_enable = 1, go to WAIT.
- WAIT:
  - Hold enable and address.
  - On the first edge with mem_read_ready == 1: capture nxt = mem_read_data[INDEX_WIDTH-1:0], go to RELEASE.
  - No timeout.
- RELEASE:
  - mem_read_enable = 0 for exactly one cycle, so there is at least one idle cycle between reads.
  - If nxt == `NO_PREVIOUS_NODE, nxt >= N, or path_length == N: set error (unreachable or cycle), go to FINISH.
  - Otherwise cur = nxt, go to EMIT.
- FINISH:
  - Release the bus to Z; path_valid = 0; go to IDLE.
  - done and error persist in IDLE until the next start.
- source == destination: one node is emitted with path_last = 1 and no memory read; done.
- Latency per hop: 1 EMIT cycle (if path_ready) + 1 REQ + BlockRam latency + 1 RELEASE.
- Memory bus: exactly one of mem_read_enable / mem_write_enable is owned at a time. This block never drives mem_write_enable or mem_write_data.
- Path order is destination first, source last.

Decomposition:
- Add `NO_PREVIOUS_NODE, the DEFAULT_* widths and a PREV_OFFSET(N) macro (N*N) to the shared constants.v.
- The state encoding enum lives locally.
- One natural sub-module: prev_addr_gen (combinational base/offset/stride address calculation), shared with the Dijkstra core's prev writer.

Test Plan:
- N=8, prev[7]=5, prev[5]=2, prev[2]=0, source 0, dest 7, path_ready tied 1 -> path_node stream 7,5,2,0; path_last only on 0; path_length=4; done=1, error=0.
- Same graph, path_ready toggling every other cycle -> identical stream; path_node stable while valid && !ready.
- source=dest=3 -> single node 3 with path_last=1, zero mem_read_enable pulses, done=1.
- prev[6]=`NO_PREVIOUS_NODE, dest 6, source 0 -> emits 6 then error=1, done=0, no further output.
- Cycle: prev[4]=1, prev[1]=4, N=8, dest 4, source 0 -> at most 8 nodes emitted, then error=1.
- Reset asserted while in WAIT -> next cycle all outputs at reset values and bus at Z; a subsequent start with the first graph completes normally.
